// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared request encodings, AXI burst codes, FSM states and type-to-burst mapping
package cache_axi_pkg;
  typedef enum logic [2:0] {
    T_BYTE = 3'b000,
    T_HALF = 3'b001,
    T_WORD = 3'b010,
    T_LINE = 3'b100
  } req_type_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] LINE_LAST = 2'd3;
  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA
  } rd_state_e;
  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } wr_state_e;
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } xfer_t;
  // Line requests are four-beat word bursts; illegal codes fall back to a single word.
  function automatic xfer_t map_type(input logic [2:0] t);
    xfer_t x;
    x.len = (t == T_LINE) ? 8'd3 : 8'd0;
    x.size = (t[2] || t[1:0] == 2'b11) ? SIZE_WORD : {1'b0, t[1:0]};
    return x;
  endfunction
endpackage

// File: rtl/axi_wbeat_shifter.sv
// axi_wbeat_shifter: holds an accepted write line and presents it one 32-bit W beat at a time
module axi_wbeat_shifter
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         line,
  input  logic         advance,
  input  logic [127:0] data,
  input  logic [3:0]   strb,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast
);
  logic [127:0] data_q;
  logic [3:0]   strb_q;
  logic         line_q;
  logic [1:0]   beat;
  // capture the request on acceptance; each W handshake steps the beat, saturating at the last one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      strb_q <= '0;
      line_q <= 1'b0;
      beat   <= '0;
    end else if (load) begin
      data_q <= data;
      strb_q <= strb;
      line_q <= line;
      beat   <= '0;
    end else if (advance && !wlast) begin
      beat <= beat + 2'd1;
    end
  end
  assign wlast = beat == (line_q ? LINE_LAST : 2'd0);
  assign wdata = data_q[{beat, 5'd0} +: 32];
  assign wstrb = line_q ? 4'hf : strb_q;
endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns cache refill/writeback requests into AXI4 read and write bursts
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [1:0]   ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  rd_state_e   r_state, r_next;
  wr_state_e   w_state, w_next;
  logic [31:0] r_addr, w_addr;
  xfer_t       r_xfer, w_xfer;
  logic        aw_done, w_done;
  logic        rd_acc, wr_acc, aw_hs, w_hs, sh_wlast, hazard;
  logic        unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign hazard  = (w_state != W_IDLE) && (rd_addr[31:4] == w_addr[31:4]);
  assign rd_rdy  = (r_state == R_IDLE) && !hazard;
  assign rd_acc  = rd_req && rd_rdy;
  assign wr_rdy  = w_state == W_IDLE;
  assign wr_acc  = wr_req && wr_rdy;
  assign arid    = RD_ID;
  assign araddr  = r_addr;
  assign arlen   = r_xfer.len;
  assign arsize  = r_xfer.size;
  assign arburst = (r_state == R_IDLE) ? 2'b00 : BURST_INCR;
  assign arvalid = r_state == R_AR;
  assign rready  = r_state == R_DATA;
  assign ret_valid = rready && rvalid;
  assign ret_data  = rready ? rdata : 32'd0;
  assign ret_last  = {1'b0, rready && rlast};
  assign awid    = WR_ID;
  assign awaddr  = w_addr;
  assign awlen   = w_xfer.len;
  assign awsize  = w_xfer.size;
  assign awburst = (w_state == W_IDLE) ? 2'b00 : BURST_INCR;
  assign awvalid = (w_state == W_SEND) && !aw_done;
  assign wvalid  = (w_state == W_SEND) && !w_done;
  assign wlast   = (w_state == W_SEND) && sh_wlast;
  assign bready  = w_state == W_RESP;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  axi_wbeat_shifter u_shifter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (wr_acc),
    .line    (wr_type == T_LINE),
    .advance (w_hs),
    .data    (wr_data),
    .strb    (wr_wstrb),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (sh_wlast)
  );
  // read state and the request it is serving
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_xfer  <= '0;
    end else begin
      r_state <= r_next;
      if (rd_acc) begin
        r_addr <= rd_addr;
        r_xfer <= map_type(rd_type);
      end
    end
  end
  // read sequencing: request, address phase, then beats until rlast
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  r_next = rd_acc ? R_AR : R_IDLE;
      R_AR:    r_next = arready ? R_DATA : R_AR;
      R_DATA:  r_next = (rvalid && rlast) ? R_IDLE : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end
  // write state, request and per-channel completion flags for AW and the last W beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_xfer  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (wr_acc) begin
        w_addr  <= wr_addr;
        w_xfer  <= map_type(wr_type);
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs && sh_wlast) w_done <= 1'b1;
      end
    end
  end
  // write sequencing: AW and W complete in any order before waiting for B
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  w_next = wr_acc ? W_SEND : W_IDLE;
      W_SEND:  w_next = ((aw_done || aw_hs) && (w_done || (w_hs && sh_wlast))) ? W_RESP : W_SEND;
      W_RESP:  w_next = bvalid ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
endmodule
